// File: rtl/fixed_mult_lfsr_pkg.sv
// fixed_mult_lfsr_pkg: shared defaults and helpers for the LFSR-scaled
// fixed-point multiplier (fixed_mult_lfsr, fixed_mult_lfsr_step).
package fixed_mult_lfsr_pkg;

  localparam int          DEF_IN_A_WIDTH = 8;
  localparam int          DEF_LFSR_WIDTH = 8;
  localparam logic [31:0] DEF_LFSR_POLY  = 32'h04C11DB7;
  localparam int          DEF_LOWER      = 2;
  localparam int          DEF_UPPER      = 8;

  // True when x is a positive power of two.
  function automatic bit is_pow2(input int x);
    return (x > 0) && ((x & (x - 1)) == 0);
  endfunction

  // AND-mask that keeps the multiplier strictly below the upper bound.
  function automatic int mult_mask(input int upper);
    return upper - 1;
  endfunction

endpackage

// File: rtl/fixed_mult_lfsr_step.sv
// fixed_mult_lfsr_step: one combinational Galois/CRC-form LFSR step.
// next = {state[W-2:0],0} ^ (state[W-1] ? POLY[W-1:0] : 0).
// A zero result (only possible with a polynomial whose bit 0 is clear)
// is replaced by all ones so the register can never lock up at zero.
module fixed_mult_lfsr_step #(
  parameter int          W    = 8,
  parameter logic [31:0] POLY = 32'h04C11DB7
) (
  input  logic [W-1:0] state_i,
  output logic [W-1:0] next_o
);

  localparam logic [W-1:0] POLY_W = POLY[W-1:0];

  logic [W-1:0] raw;

  // Shift left and fold the polynomial in when the MSB falls out.
  always_comb begin
    raw    = {state_i[W-2:0], 1'b0} ^ (state_i[W-1] ? POLY_W : '0);
    next_o = (raw == '0) ? '1 : raw;
  end

endmodule

// File: rtl/fixed_mult_lfsr.sv
// fixed_mult_lfsr: multiplies a signed operand by an LFSR-derived unsigned
// multiplier mult = (next | LOWER) & (UPPER-1), registered with a
// single-entry valid/ready output stage.
// Optional build macro: FIXED_MULT_LFSR_FREE_RUN_EN -- when defined the LFSR
// advances every clock out of reset; otherwise it advances only on accept.
//
// Handshake: a transfer happens on a clk edge where valid && ready are both
// high. data_in_ready = !data_out_valid || data_out_ready, so a new input is
// taken whenever the output slot is empty or is being drained this cycle.
// While data_out_valid && !data_out_ready, product_out is held stable.
module fixed_mult_lfsr
  import fixed_mult_lfsr_pkg::*;
#(
  parameter int          IN_A_WIDTH = DEF_IN_A_WIDTH,
  parameter int          LFSR_WIDTH = DEF_LFSR_WIDTH,
  parameter logic [31:0] LFSR_POLY  = DEF_LFSR_POLY,
  parameter int          LOWER      = DEF_LOWER,
  parameter int          UPPER      = DEF_UPPER
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [IN_A_WIDTH-1:0]            data_in,
  input  logic                             data_in_valid,
  output logic                             data_in_ready,
  output logic [IN_A_WIDTH+LFSR_WIDTH-1:0] product_out,
  output logic                             data_out_valid,
  input  logic                             data_out_ready,
  output logic [LFSR_WIDTH-1:0]            lfsr_state
);

  localparam int PW = IN_A_WIDTH + LFSR_WIDTH;
  localparam logic [LFSR_WIDTH-1:0] LOWER_V   = LFSR_WIDTH'(LOWER);
  localparam logic [LFSR_WIDTH-1:0] MULT_MASK = LFSR_WIDTH'(mult_mask(UPPER));

  // Reject illegal multiplier bounds and widths at elaboration.
  generate
    if (!is_pow2(LOWER) || !is_pow2(UPPER) || (LOWER >= UPPER)) begin : g_bad_bounds
      $error("fixed_mult_lfsr: LOWER/UPPER must be powers of two with LOWER < UPPER");
    end
    if ((LFSR_WIDTH < 2) || (LFSR_WIDTH > 32)) begin : g_bad_width
      $error("fixed_mult_lfsr: LFSR_WIDTH must be in 2..32");
    end
  endgenerate

  logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_d;
  logic [PW-1:0]         prod_q, prod_d;
  logic                  out_valid_q, out_valid_d;

  logic [LFSR_WIDTH-1:0] lfsr_next;
  logic [LFSR_WIDTH-1:0] mult;
  logic [PW-1:0]         a_ext;
  logic [PW-1:0]         m_ext;
  logic [PW-1:0]         product;
  logic                  accept;

  fixed_mult_lfsr_step #(
    .W    (LFSR_WIDTH),
    .POLY (LFSR_POLY)
  ) u_step (
    .state_i (lfsr_q),
    .next_o  (lfsr_next)
  );

  assign data_in_ready  = !out_valid_q || data_out_ready;
  assign accept         = data_in_valid && data_in_ready;
  assign product_out    = prod_q;
  assign data_out_valid = out_valid_q;
  assign lfsr_state     = lfsr_q;

  // Multiplier from the LFSR step; signed x zero-extended unsigned product.
  // The true product always fits in PW signed bits, so a PW-bit multiply
  // of the sign/zero-extended operands yields the exact result.
  always_comb begin
    mult    = (lfsr_next | LOWER_V) & MULT_MASK;
    a_ext   = {{LFSR_WIDTH{data_in[IN_A_WIDTH-1]}}, data_in};
    m_ext   = {{IN_A_WIDTH{1'b0}}, mult};
    product = a_ext * m_ext;
  end

  // Next-state for the output slot and the LFSR.
  always_comb begin
    prod_d      = prod_q;
    out_valid_d = out_valid_q;
    lfsr_d      = lfsr_q;
    if (accept) begin
      prod_d      = product;
      out_valid_d = 1'b1;
    end else if (data_out_ready) begin
      out_valid_d = 1'b0;
    end
`ifdef FIXED_MULT_LFSR_FREE_RUN_EN
    lfsr_d = lfsr_next;
`else
    if (accept) begin
      lfsr_d = lfsr_next;
    end
`endif
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q      <= '1;
      prod_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      lfsr_q      <= lfsr_d;
      prod_q      <= prod_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_fixed_mult_lfsr.sv
// tb_fixed_mult_lfsr: directed-vector bench for fixed_mult_lfsr (default
// build, LFSR advances on accept). Expected values are hand-computed from
// poly low byte 0xB7, mask 7, LOWER 2.
module tb_fixed_mult_lfsr;

  logic        clk;
  logic        rst_n;
  logic [7:0]  data_in;
  logic        data_in_valid;
  logic        data_in_ready;
  logic [15:0] product_out;
  logic        data_out_valid;
  logic        data_out_ready;
  logic [7:0]  lfsr_state;

  int checks = 0;
  int errors = 0;

  fixed_mult_lfsr dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .data_in_ready  (data_in_ready),
    .product_out    (product_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .lfsr_state     (lfsr_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle 1ns past it.
  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    data_in        = 8'h00;
    data_in_valid  = 1'b0;
    data_out_ready = 1'b1;
    step_clk();
    step_clk();
    checks++;
    if (lfsr_state !== 8'hFF) begin
      errors++;
      $display("FAIL reset_lfsr: got %h expected ff", lfsr_state);
    end
    checks++;
    if (data_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b expected 0", data_out_valid);
    end
    checks++;
    if (data_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 1", data_in_ready);
    end
    checks++;
    if (product_out !== 16'h0000) begin
      errors++;
      $display("FAIL reset_product: got %h expected 0000", product_out);
    end
    rst_n = 1'b1;
    step_clk();
  endtask

  task automatic test_accept();
    logic [7:0]  din [3] = '{8'hFE, 8'h05, 8'h80};
    logic [15:0] exp_p [3] = '{16'hFFFA, 16'h000A, 16'hFE80};
    logic [7:0]  exp_l [3] = '{8'h49, 8'h92, 8'h93};
    for (int i = 0; i < 3; i++) begin
      data_in        = din[i];
      data_in_valid  = 1'b1;
      data_out_ready = 1'b1;
      step_clk();
      checks++;
      if (product_out !== exp_p[i]) begin
        errors++;
        $display("FAIL accept_product[%0d]: got %h expected %h", i, product_out, exp_p[i]);
      end
      checks++;
      if (lfsr_state !== exp_l[i]) begin
        errors++;
        $display("FAIL accept_lfsr[%0d]: got %h expected %h", i, lfsr_state, exp_l[i]);
      end
      checks++;
      if (data_out_valid !== 1'b1) begin
        errors++;
        $display("FAIL accept_valid[%0d]: got %b expected 1", i, data_out_valid);
      end
    end
    // Consume with no new input: valid clears, LFSR does not move.
    data_in_valid = 1'b0;
    step_clk();
    checks++;
    if (data_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_valid: got %b expected 0", data_out_valid);
    end
    checks++;
    if (lfsr_state !== 8'h93) begin
      errors++;
      $display("FAIL idle_lfsr: got %h expected 93", lfsr_state);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  din [3] = '{8'h07, 8'hFF, 8'h10};
    logic [15:0] exp_p [3] = '{16'h0031, 16'hFFF9, 16'h0070};
    logic [7:0]  exp_l [3] = '{8'h95, 8'h9D, 8'h8D};
    // Fill the slot: next 0x91, mult 3, 3*3 = 9.
    data_in        = 8'h03;
    data_in_valid  = 1'b1;
    data_out_ready = 1'b1;
    step_clk();
    checks++;
    if (product_out !== 16'h0009) begin
      errors++;
      $display("FAIL fill_product: got %h expected 0009", product_out);
    end
    // Stall for 3 cycles with input waiting.
    data_in        = din[0];
    data_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (data_in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_ready[%0d]: got %b expected 0", i, data_in_ready);
      end
      step_clk();
      checks++;
      if (product_out !== 16'h0009 || lfsr_state !== 8'h91 || data_out_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got p=%h l=%h v=%b expected p=0009 l=91 v=1",
                 i, product_out, lfsr_state, data_out_valid);
      end
    end
    // Release: one accept per cycle.
    data_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_in = din[i];
      step_clk();
      checks++;
      if (product_out !== exp_p[i] || lfsr_state !== exp_l[i] || data_out_valid !== 1'b1) begin
        errors++;
        $display("FAIL b2b[%0d]: got p=%h l=%h v=%b expected p=%h l=%h v=1",
                 i, product_out, lfsr_state, data_out_valid, exp_p[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    data_in_valid  = 1'b0;
    data_out_ready = 1'b0;
    #1;
    checks++;
    if (data_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre_valid: got %b expected 1", data_out_valid);
    end
    rst_n = 1'b0;
    step_clk();
    checks++;
    if (data_out_valid !== 1'b0 || lfsr_state !== 8'hFF || product_out !== 16'h0000) begin
      errors++;
      $display("FAIL mid_reset: got v=%b l=%h p=%h expected v=0 l=ff p=0000",
               data_out_valid, lfsr_state, product_out);
    end
    rst_n = 1'b1;
    // First accept after reset restarts the sequence: 0xFF -> 0x49, mult 3.
    data_in        = 8'h02;
    data_in_valid  = 1'b1;
    data_out_ready = 1'b1;
    step_clk();
    checks++;
    if (product_out !== 16'h0006 || lfsr_state !== 8'h49) begin
      errors++;
      $display("FAIL post_reset: got p=%h l=%h expected p=0006 l=49", product_out, lfsr_state);
    end
    data_in_valid = 1'b0;
    step_clk();
  endtask

  initial begin
    rst_n          = 1'b0;
    data_in        = '0;
    data_in_valid  = 1'b0;
    data_out_ready = 1'b0;
    test_reset();
    test_accept();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
